// File: rtl/mon_exp_ctrl.sv
// mon_exp_ctrl: accepts one Montgomery exponentiation job and loads X_bar/M_bar
// into the shared bram through write port 2. It then starts mon_exp, waits for
// the rising edge of its stop flag (or a timeout), and returns the result over
// a valid/ready response handshake.
module mon_exp_ctrl #(
    parameter int BITLEN    = 1024,
    parameter int DBITS     = 512,
    parameter int ABITS     = 8,
    parameter int BASE_ADDR = 0,
    parameter int TIMEOUT   = 1048576
) (
    input  logic              clk,
    input  logic              rst_n,
    // job request
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [BITLEN-1:0] req_x_bar,
    input  logic [BITLEN-1:0] req_m_bar,
    input  logic [BITLEN-1:0] req_e,
    input  logic [BITLEN-1:0] req_n,
    input  logic [9:0]        req_e_idx,
    input  logic [9:0]        req_mp_count,
    // job response
    output logic              res_valid,
    input  logic              res_ready,
    output logic [BITLEN:0]   res_ans,
    output logic              res_err,
    output logic              busy,
    // mon_exp datapath
    output logic              me_start,
    output logic [BITLEN-1:0] me_e,
    output logic [BITLEN-1:0] me_n,
    output logic [9:0]        me_e_idx,
    output logic [9:0]        me_mp_count,
    input  logic              me_stop,
    input  logic [BITLEN:0]   me_ans,
    // bram write port 2
    output logic [ABITS-1:0]  wr_addr2,
    output logic [DBITS-1:0]  wr_data2,
    output logic              wr_en2
);

    // The counter only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
    localparam int              CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [ABITS-1:0] BASE    = ABITS'(BASE_ADDR);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD0,
        S_LOAD1,
        S_LOAD2,
        S_LOAD3,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    // The low X word is written straight from the request in LOAD0, so only
    // the upper X word and both M words need to be kept.
    logic [BITLEN-DBITS-1:0] x_hi;
    logic [BITLEN-1:0]       m_q;
    logic                    stop_q;
    logic [CW-1:0]           cnt;

    logic                    accept;
    logic                    stop_rise;
    logic                    timeout;
    logic [ABITS-1:0]        addr_nxt;
    logic [DBITS-1:0]        data_nxt;

    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign res_valid = (state == S_DONE);
    assign me_start  = (state == S_START);
    assign wr_en2    = (state == S_LOAD0) || (state == S_LOAD1) ||
                       (state == S_LOAD2) || (state == S_LOAD3);

    assign accept    = req_valid && req_ready;
    // A stop level left high by a previous job is not an edge and never completes.
    assign stop_rise = me_stop && !stop_q;
    assign timeout   = (cnt == CNT_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values regardless of statement order.
            state <= state_nxt;
        end
    end

    // Next-state logic plus the word/address to be presented in the next LOAD cycle.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_nxt = state;
        addr_nxt  = wr_addr2;
        data_nxt  = wr_data2;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_LOAD0;
                    addr_nxt  = BASE;
                    data_nxt  = req_x_bar[DBITS-1:0];
                end
            end
            S_LOAD0: begin
                state_nxt = S_LOAD1;
                addr_nxt  = BASE + ABITS'(1);
                data_nxt  = x_hi;
            end
            S_LOAD1: begin
                state_nxt = S_LOAD2;
                addr_nxt  = BASE + ABITS'(2);
                data_nxt  = m_q[DBITS-1:0];
            end
            S_LOAD2: begin
                state_nxt = S_LOAD3;
                addr_nxt  = BASE + ABITS'(3);
                data_nxt  = m_q[BITLEN-1:DBITS];
            end
            S_LOAD3: state_nxt = S_START;
            S_START: state_nxt = S_WAIT;
            S_WAIT: begin
                if (stop_rise || timeout) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, bram port-2 registers, stop sampling, timeout counter and result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_hi        <= '0;
            m_q         <= '0;
            me_e        <= '0;
            me_n        <= '0;
            me_e_idx    <= '0;
            me_mp_count <= '0;
            wr_addr2    <= '0;
            wr_data2    <= '0;
            stop_q      <= 1'b0;
            cnt         <= '0;
            res_ans     <= '0;
            res_err     <= 1'b0;
        end else begin
            stop_q   <= me_stop;
            wr_addr2 <= addr_nxt;
            wr_data2 <= data_nxt;

            if (accept) begin
                x_hi        <= req_x_bar[BITLEN-1:DBITS];
                m_q         <= req_m_bar;
                me_e        <= req_e;
                me_n        <= req_n;
                me_e_idx    <= req_e_idx;
                me_mp_count <= req_mp_count;
            end

            if (state == S_START) begin
                cnt <= '0;
            end else if (state == S_WAIT) begin
                cnt <= cnt + CW'(1);
            end

            // Completion takes priority over a timeout in the same cycle.
            if (state == S_WAIT) begin
                if (stop_rise) begin
                    res_ans <= me_ans;
                    res_err <= 1'b0;
                end else if (timeout) begin
                    res_ans <= '0;
                    res_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mon_exp_ctrl.sv
// Directed testbench for mon_exp_ctrl: a cycle table for the nominal job plus
// hand-written sequences for backpressure, stale stop, timeout and reset aborts.
module tb_mon_exp_ctrl;

    localparam int BITLEN  = 1024;
    localparam int DBITS   = 512;
    localparam int ABITS   = 8;
    localparam int TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [BITLEN-1:0] req_x_bar = '0, req_m_bar = '0, req_e = '0, req_n = '0;
    logic [9:0]        req_e_idx = '0, req_mp_count = '0;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [BITLEN:0]   res_ans;
    logic              res_err, busy, me_start;
    logic [BITLEN-1:0] me_e, me_n;
    logic [9:0]        me_e_idx, me_mp_count;
    logic              me_stop = 1'b0;
    logic [BITLEN:0]   me_ans = '0;
    logic [ABITS-1:0]  wr_addr2;
    logic [DBITS-1:0]  wr_data2;
    logic              wr_en2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mon_exp_ctrl #(
        .BITLEN(BITLEN), .DBITS(DBITS), .ABITS(ABITS), .BASE_ADDR(0), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x_bar(req_x_bar), .req_m_bar(req_m_bar), .req_e(req_e), .req_n(req_n),
        .req_e_idx(req_e_idx), .req_mp_count(req_mp_count),
        .res_valid(res_valid), .res_ready(res_ready), .res_ans(res_ans), .res_err(res_err),
        .busy(busy), .me_start(me_start), .me_e(me_e), .me_n(me_n),
        .me_e_idx(me_e_idx), .me_mp_count(me_mp_count), .me_stop(me_stop), .me_ans(me_ans),
        .wr_addr2(wr_addr2), .wr_data2(wr_data2), .wr_en2(wr_en2)
    );

    typedef struct {
        logic             req_valid;
        logic             me_stop;
        logic             exp_req_ready;
        logic             exp_busy;
        logic             exp_wr_en2;
        logic [ABITS-1:0] exp_addr;
        logic [DBITS-1:0] exp_data;
        logic             exp_me_start;
        logic             exp_res_valid;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [BITLEN:0] act, input logic [BITLEN:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_job(input logic [BITLEN-1:0] x, m, e, n, input logic [9:0] eidx, mp);
        req_x_bar = x; req_m_bar = m; req_e = e; req_n = n;
        req_e_idx = eidx; req_mp_count = mp;
        req_valid = 1'b1;
        @(negedge clk);
        check("accept_req_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
    endtask

    // From the LOAD0 cycle, skip the loads and check the start pulse; ends at WAIT entry.
    task automatic to_wait();
        repeat (4) tick();
        @(negedge clk);
        check("start_pulse", me_start, 1);
        tick();
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        @(negedge clk);
        check("hs_res_valid", res_valid, 1);
        tick();
        res_ready = 1'b0;
        @(negedge clk);
        check("hs_back_idle", req_ready, 1);
        check("hs_res_valid_low", res_valid, 0);
    endtask

    task automatic run_job(input logic [BITLEN-1:0] x, m, e, n, input logic [9:0] eidx, mp,
                           input logic [BITLEN:0] ans, input int lat);
        logic [DBITS-1:0] words[4];
        words[0] = x[DBITS-1:0];
        words[1] = x[BITLEN-1:DBITS];
        words[2] = m[DBITS-1:0];
        words[3] = m[BITLEN-1:DBITS];
        me_ans = ans;
        accept_job(x, m, e, n, eidx, mp);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("job_wr_en2", wr_en2, 1);
            check("job_wr_addr2", wr_addr2, k);
            check("job_wr_data2", wr_data2, words[k]);
            tick();
        end
        @(negedge clk);
        check("job_me_start", me_start, 1);
        check("job_me_e", me_e, e);
        check("job_me_n", me_n, n);
        tick();
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            check("job_wait_res_valid", res_valid, 0);
            tick();
        end
        me_stop = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("job_res_valid", res_valid, 1);
        check("job_res_ans", res_ans, ans);
        check("job_res_err", res_err, 0);
        tick();
        me_stop = 1'b0;
        handshake();
        tick();
    endtask

    initial begin
        logic [BITLEN-1:0] x2, m2, e2;
        logic [BITLEN:0]   ans2;
        logic [DBITS-1:0]  words2[4];

        vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 512'd0,   1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 512'd435, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1, 512'd0,   1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd2, 512'd571, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd3, 512'd0,   1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3, 512'd0,   1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3, 512'd0,   1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3, 512'd0,   1'b0, 1'b0};

        // ---- reset with toggling inputs ----
        for (int i = 0; i < 4; i++) begin
            #1;
            req_valid = 1'($urandom);
            res_ready = 1'($urandom);
            me_stop   = 1'($urandom);
            req_e     = BITLEN'($urandom);
            req_x_bar = BITLEN'($urandom);
            me_ans    = (BITLEN + 1)'($urandom);
            @(posedge clk);
        end
        @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_err", res_err, 0);
        check("rst_me_start", me_start, 0);
        check("rst_wr_en2", wr_en2, 0);
        check("rst_res_ans", res_ans, 0);
        check("rst_me_e", me_e, 0);
        check("rst_me_n", me_n, 0);
        check("rst_me_e_idx", me_e_idx, 0);
        check("rst_me_mp_count", me_mp_count, 0);
        check("rst_wr_addr2", wr_addr2, 0);
        check("rst_wr_data2", wr_data2, 0);
        req_valid = 1'b0; res_ready = 1'b0; me_stop = 1'b0;
        rst_n = 1'b1;
        tick();

        // ---- nominal job, cycle table ----
        req_x_bar = 435; req_m_bar = 571; req_e = 300; req_n = 589;
        req_e_idx = 8; req_mp_count = 10; me_ans = 'h1A5;
        for (int i = 0; i < 8; i++) begin
            req_valid = vecs[i].req_valid;
            me_stop   = vecs[i].me_stop;
            @(negedge clk);
            check($sformatf("vec%0d_req_ready", i), req_ready, vecs[i].exp_req_ready);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
            check($sformatf("vec%0d_wr_en2", i), wr_en2, vecs[i].exp_wr_en2);
            check($sformatf("vec%0d_wr_addr2", i), wr_addr2, vecs[i].exp_addr);
            check($sformatf("vec%0d_wr_data2", i), wr_data2, vecs[i].exp_data);
            check($sformatf("vec%0d_me_start", i), me_start, vecs[i].exp_me_start);
            check($sformatf("vec%0d_res_valid", i), res_valid, vecs[i].exp_res_valid);
            tick();
        end
        check("nom_me_e", me_e, 300);
        check("nom_me_n", me_n, 589);
        check("nom_me_e_idx", me_e_idx, 8);
        check("nom_me_mp_count", me_mp_count, 10);
        // start was cycle 5; stop rises in cycle 25
        for (int c = 8; c < 25; c++) begin
            @(negedge clk);
            check("nom_wait_res_valid", res_valid, 0);
            tick();
        end
        me_stop = 1'b1;
        @(negedge clk);
        check("nom_edge_res_valid", res_valid, 0);
        tick();
        @(negedge clk);
        check("nom_res_valid", res_valid, 1);
        check("nom_res_ans", res_ans, 'h1A5);
        check("nom_res_err", res_err, 0);

        // ---- backpressure with a second request held high ----
        x2   = (BITLEN'('h5A) << DBITS) | BITLEN'('h77);
        m2   = (BITLEN'('hC3) << DBITS) | BITLEN'('h99);
        e2   = 777;
        ans2 = 'h2B7;
        words2[0] = 'h77; words2[1] = 'h5A; words2[2] = 'h99; words2[3] = 'hC3;
        req_x_bar = x2; req_m_bar = m2; req_e = e2; req_n = 1001;
        req_valid = 1'b1; res_ready = 1'b0; me_ans = ans2;
        tick();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_res_valid", res_valid, 1);
            check("bp_res_ans", res_ans, 'h1A5);
            check("bp_req_ready", req_ready, 0);
            check("bp_me_e", me_e, 300);
            tick();
        end
        res_ready = 1'b1;
        @(negedge clk);
        check("bp_hs_res_valid", res_valid, 1);
        tick();
        res_ready = 1'b0;
        @(negedge clk);
        check("bp_idle_req_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("j2_wr_en2", wr_en2, 1);
            check("j2_wr_addr2", wr_addr2, k);
            check("j2_wr_data2", wr_data2, words2[k]);
            tick();
        end
        @(negedge clk);
        check("j2_me_start", me_start, 1);
        check("j2_me_e", me_e, e2);
        tick();

        // ---- stale stop: held high, drops 3 cycles after start, re-rises at 13 ----
        for (int k = 1; k <= 13; k++) begin
            me_stop = (k < 3) || (k == 13);
            @(negedge clk);
            check("stale_res_valid", res_valid, 0);
            check("stale_me_start", me_start, 0);
            tick();
        end
        @(negedge clk);
        check("stale_res_valid_done", res_valid, 1);
        check("stale_res_ans", res_ans, ans2);
        check("stale_res_err", res_err, 0);
        tick();
        handshake();
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stale_single_completion", res_valid, 0);
            check("stale_idle_busy", busy, 0);
            tick();
        end
        me_stop = 1'b0;

        // ---- timeout: stop never rises ----
        me_ans = 'h55;
        accept_job(11, 22, 33, 44, 5, 6);
        to_wait();
        for (int j = 0; j < TIMEOUT; j++) begin
            @(negedge clk);
            check("to_wait_res_valid", res_valid, 0);
            tick();
        end
        @(negedge clk);
        check("to_res_valid", res_valid, 1);
        check("to_res_err", res_err, 1);
        check("to_res_ans", res_ans, 0);
        tick();
        handshake();
        tick();

        // ---- stop edge in the final counter cycle: completion wins ----
        me_ans = 'h3C3;
        accept_job(1, 2, 3, 4, 1, 2);
        to_wait();
        for (int j = 0; j < TIMEOUT; j++) begin
            me_stop = (j == TIMEOUT - 1);
            @(negedge clk);
            check("tie_wait_res_valid", res_valid, 0);
            tick();
        end
        @(negedge clk);
        check("tie_res_valid", res_valid, 1);
        check("tie_res_err", res_err, 0);
        check("tie_res_ans", res_ans, 'h3C3);
        tick();
        me_stop = 1'b0;
        handshake();
        tick();

        // ---- reset mid-WAIT ----
        accept_job(7, 8, 9, 10, 3, 4);
        to_wait();
        repeat (3) tick();
        #2;
        check("rw_pre_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("rw_wr_en2", wr_en2, 0);
        check("rw_me_start", me_start, 0);
        check("rw_busy", busy, 0);
        check("rw_req_ready", req_ready, 1);
        check("rw_res_ans", res_ans, 0);
        check("rw_me_e", me_e, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        check("rw_idle_after", req_ready, 1);
        tick();

        // ---- reset mid-LOAD2 ----
        accept_job(12, 13, 14, 15, 2, 3);
        tick();
        tick();
        #1;
        check("rl_pre_wr_en2", wr_en2, 1);
        check("rl_pre_wr_addr2", wr_addr2, 2);
        rst_n = 1'b0;
        #1;
        check("rl_wr_en2", wr_en2, 0);
        check("rl_me_start", me_start, 0);
        check("rl_wr_addr2", wr_addr2, 0);
        check("rl_wr_data2", wr_data2, 0);
        check("rl_req_ready", req_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        check("rl_idle_after", req_ready, 1);
        tick();

        // ---- nominal job after the aborts ----
        run_job(435, 571, 300, 589, 8, 10, 'h1A5, 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Bound the run in case a sequence above stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mon_exp_ctrl.md
# mon_exp_ctrl

Sequencer for the Montgomery exponentiation datapath (`mon_exp`) and its shared `bram`. It accepts one exponentiation job per request handshake and writes the X_bar and M_bar operands into `bram` through write port 2. It then pulses `start` to `mon_exp`, waits for completion, and returns the result over a valid/ready response handshake. Software and top-level glue no longer drive the `bram` load or the `start`/`stop` protocol.

## Interface
- `BITLEN`, 1024: operand width; must equal 2*`DBITS`.
- `DBITS`, 512: `bram` word width.
- `ABITS`, 8: `bram` address width.
- `BASE_ADDR`, 0: first `bram` address of the 4-word operand block.
- `TIMEOUT`, 1048576: maximum cycles spent in WAIT before the job is aborted.
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  job request.
- `req_ready`  out  1  controller can accept a job (high only in IDLE).
- `req_x_bar`, `req_m_bar`  in  BITLEN  operands in the Montgomery domain.
- `req_e`, `req_n`  in  BITLEN  exponent and modulus.
- `req_e_idx`, `req_mp_count`  in  10  exponent MSB index and mon_prod iteration count.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  result consumed.
- `res_ans`  out  BITLEN+1  captured `ans`.
- `res_err`  out  1  job ended by timeout.
- `busy`  out  1  state is not IDLE.
- `me_start`  out  1  one-cycle start pulse to `mon_exp`.
- `me_e`, `me_n`  out  BITLEN  registered operands to `mon_exp`.
- `me_e_idx`, `me_mp_count`  out  10  registered operands to `mon_exp`.
- `me_stop`  in  1  `mon_exp` completion.
- `me_ans`  in  BITLEN+1  `mon_exp` result.
- `wr_addr2`  out  ABITS  `bram` port-2 address.
- `wr_data2`  out  DBITS  `bram` port-2 data.
- `wr_en2`  out  1  `bram` port-2 write enable.

## Operation
- States: IDLE, LOAD0..LOAD3, START, WAIT, DONE.
- IDLE: `req_ready`=1. On `req_valid`&&`req_ready`, register all `req_*` fields into the `me_*` outputs and internal X/M registers, then go to LOAD0. `me_*` operands stay stable until the next accept.
- LOADk (k=0..3): `wr_en2`=1, `wr_addr2`=`BASE_ADDR`+k. Data per word:
  - k=0: X[DBITS-1:0]
  - k=1: X[BITLEN-1:DBITS]
  - k=2: M[DBITS-1:0]
  - k=3: M[BITLEN-1:DBITS]
- Address arithmetic is modulo 2^ABITS; wrap above the top address is permitted, not flagged.
- START: `me_start`=1 for exactly one cycle, then WAIT. The timeout counter clears on entry to WAIT.
- Completion detect: `stop_q` registers `me_stop` every cycle.
  - Completion is the rising edge `me_stop`&&!`stop_q`, detected in WAIT only.
  - A `me_stop` level held high from a previous job never completes a new job; it must fall and rise again.
- WAIT on completion: capture `me_ans` into `res_ans`, `res_err`=0, go to DONE.
- WAIT on timeout: if the counter reaches `TIMEOUT`-1 with no completion, `res_ans`=0, `res_err`=1, go to DONE.
  - Completion and timeout in the same cycle: completion wins.
  - `mon_exp` has no abort; software must not trust `bram` contents after an error.
- DONE: `res_valid`=1, `res_ans`/`res_err` held. On `res_ready`, go to IDLE.
- `req_valid` outside IDLE is ignored (not queued).
- `wr_en2` and `me_start` are 0 in every state except LOADk and START respectively.
- `wr_addr2`/`wr_data2` hold their last values when `wr_en2`=0.

## Timing
- Reset (async assert, sync release): state=IDLE.
  - `req_ready`=1.
  - `busy`, `res_valid`, `res_err`, `me_start`, `wr_en2`=0.
  - `res_ans`, `me_*`, `wr_addr2`, `wr_data2`, `stop_q`, counter = 0.
- Reset asserted in any state, including mid-LOAD or WAIT, aborts immediately to the reset values.
- With the request accepted at edge T:
  - LOAD writes occur in cycles T+1..T+4.
  - `me_start` is high in cycle T+5.
  - WAIT begins at T+6.
- A stop rising edge sampled at edge S gives `res_valid`=1 in cycle S+1.
- A response handshake at edge R returns to IDLE; `req_ready`=1 in cycle R+1.
- Minimum job turnaround: 8 cycles plus `mon_exp` latency.

## Test plan
- Reset: hold `rst_n`=0 mid-cycle, all toggling inputs -> every output at its reset value, `req_ready`=1.
- Nominal job: x_bar=435, m_bar=571, e=300, e_idx=8, n=589, mp_count=10, `BASE_ADDR`=0.
  - Port-2 writes in order: (0,435), (1,0), (2,571), (3,0).
  - `me_start` is a single pulse at T+5.
  - `mon_exp` stub raises stop 20 cycles later with ans=0x1A5 -> `res_valid` next cycle, `res_ans`=0x1A5, `res_err`=0.
- Backpressure/back-to-back: `res_ready`=0 for 10 cycles and a second `req_valid` held high throughout.
  - Result stays stable and `req_ready` stays 0 until the handshake.
  - The second job is accepted in the cycle after the handshake.
- Stale stop: stub holds `me_stop`=1 before start, drops it 3 cycles after start, re-raises it 10 cycles later -> exactly one completion, at the re-rise.
- Timeout: `TIMEOUT`=64, stub never stops -> `res_valid` 64 cycles after WAIT entry with `res_err`=1 and `res_ans`=0. A stop edge in the final counter cycle instead yields `res_err`=0.
- Reset mid-WAIT and mid-LOAD2 -> `wr_en2`=0 and `me_start`=0 immediately, IDLE afterwards. A following nominal job completes correctly.
